// File: rtl/issue_queue_pkg.sv
// Shared types for the issue queue slice.
//   qu_common       : res_st_cell_t (micro-op cell held in reservation/issue storage),
//                     ISSUE_QUEUE_DEPTH default depth.
//   issue_queue_pkg : issue-queue-local constants and helpers built on qu_common.
package qu_common;

    localparam int unsigned ISSUE_QUEUE_DEPTH = 8;

    typedef struct packed {
        logic [5:0]  tag;
        logic [3:0]  opcode;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic [5:0]  rd;
        logic [15:0] imm;
    } res_st_cell_t;

endpackage

package issue_queue_pkg;

    import qu_common::*;

    localparam int unsigned IQ_CELL_W = $bits(res_st_cell_t);

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int unsigned iq_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Issue queue bus: schedule-side push, execute-side valid/ready pop, status.
//   slave  : queue side (inputs flush/wr_en/wr_data/rd_ready; drives status and head)
//   master : producer/consumer side (drives requests, observes status and head)
interface issue_queue_if #(
    parameter int unsigned DEPTH = qu_common::ISSUE_QUEUE_DEPTH
);

    logic                         flush;
    logic                         wr_en;
    qu_common::res_st_cell_t      wr_data;
    logic                         full;
    logic                         almost_full;
    logic                         rd_valid;
    qu_common::res_st_cell_t      rd_data;
    logic                         rd_ready;
    logic [$clog2(DEPTH):0]       count;
    logic                         overflow;

    modport slave (
        input  flush, wr_en, wr_data, rd_ready,
        output full, almost_full, rd_valid, rd_data, count, overflow
    );

    modport master (
        output flush, wr_en, wr_data, rd_ready,
        input  full, almost_full, rd_valid, rd_data, count, overflow
    );

endinterface

// File: rtl/issue_queue_mem.sv
// DEPTH x WIDTH register array, one synchronous write port, one asynchronous read port.
// Contents are not reset.
//   clk      : clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : read data (combinational)
module issue_queue_mem #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/issue_queue.sv
// Issue queue: buffers scheduled micro-ops until execute accepts them.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (clears pointers, count, overflow)
//   bus  : issue_queue_if.slave (flush, push, valid/ready head, full/almost_full/count/overflow)
// Optional build macro QU_ISSUE_QUEUE_BYPASS_EN: an op written into an empty queue is
// presented on the read side in the same cycle and, if accepted, is never stored.
module issue_queue
    import qu_common::*;
    import issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = ISSUE_QUEUE_DEPTH,
    parameter int unsigned AF_LEVEL = DEPTH - 1
) (
    input  logic        clk,
    input  logic        rst,
    issue_queue_if.slave bus
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = iq_cnt_w(DEPTH);

    logic [PW-1:0]        r_wr_ptr, r_rd_ptr, w_wr_ptr_d, w_rd_ptr_d;
    logic [CW-1:0]        r_count, w_count_d;
    logic                 r_overflow, w_overflow_d;
    logic                 w_full, w_mem_valid, w_push, w_pop, w_bypass_take;
    logic [IQ_CELL_W-1:0] w_rdata;

    // Full is taken from the registered count, so a same-cycle pop never frees a slot.
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_mem_valid = (r_count != '0);

`ifdef QU_ISSUE_QUEUE_BYPASS_EN
    logic w_bypass;
    assign w_bypass      = !w_mem_valid && bus.wr_en && !bus.flush;
    assign w_bypass_take = w_bypass && bus.rd_ready;
    assign bus.rd_valid  = w_mem_valid || w_bypass;
    assign bus.rd_data   = w_mem_valid ? res_st_cell_t'(w_rdata) : bus.wr_data;
`else
    assign w_bypass_take = 1'b0;
    assign bus.rd_valid  = w_mem_valid;
    assign bus.rd_data   = res_st_cell_t'(w_rdata);
`endif

    // A bypassed op is consumed directly and must not also be stored.
    assign w_push = bus.wr_en && !bus.flush && !w_full && !w_bypass_take;
    assign w_pop  = w_mem_valid && bus.rd_ready && !bus.flush;

    always_comb begin
        w_wr_ptr_d   = r_wr_ptr;
        w_rd_ptr_d   = r_rd_ptr;
        w_count_d    = r_count;
        w_overflow_d = r_overflow | (bus.wr_en & w_full & ~bus.flush);
        if (bus.flush) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_count_d  = '0;
        end else begin
            if (w_push) w_wr_ptr_d = r_wr_ptr + PW'(1);
            if (w_pop)  w_rd_ptr_d = r_rd_ptr + PW'(1);
            w_count_d = r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_d;
            r_rd_ptr   <= w_rd_ptr_d;
            r_count    <= w_count_d;
            r_overflow <= w_overflow_d;
        end
    end

    assign bus.full        = w_full;
    assign bus.almost_full = (r_count >= CW'(AF_LEVEL));
    assign bus.count       = r_count;
    assign bus.overflow    = r_overflow;

    issue_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (IQ_CELL_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.wr_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue (DEPTH=8, AF_LEVEL=7) against a queue-based model.
module tb_issue_queue;
    import qu_common::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AF    = 7;
`ifdef QU_ISSUE_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    res_st_cell_t m_q[$];
    bit           m_ovf = 1'b0;

    issue_queue_if #(.DEPTH(DEPTH)) bus ();

    issue_queue #(.DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic res_st_cell_t mk_cell(input logic [5:0] tag);
        res_st_cell_t c;
        c        = res_st_cell_t'({$urandom, $urandom});
        c.tag    = tag;
        return c;
    endfunction

    task automatic drive(input bit wr, input res_st_cell_t d, input bit rdy, input bit fl);
        bus.wr_en    = wr;
        bus.wr_data  = d;
        bus.rd_ready = rdy;
        bus.flush    = fl;
        #1;
    endtask

    // Advance one clock and apply the queue's rules to the model.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else if (bus.flush) begin
            m_q.delete();
        end else if (BYP && m_q.size() == 0 && bus.wr_en && bus.rd_ready) begin
            // op passes straight through
        end else begin
            bit was_full = (m_q.size() == DEPTH);
            if (m_q.size() != 0 && bus.rd_ready) void'(m_q.pop_front());
            if (bus.wr_en) begin
                if (was_full) m_ovf = 1'b1;
                else          m_q.push_back(bus.wr_data);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(0, '0, 0, 0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (bus.full !== 1'b0) begin n_errors++; $display("FAIL reset_full got %b want 0", bus.full); end
        n_checks++; if (bus.almost_full !== 1'b0) begin n_errors++; $display("FAIL reset_af got %b want 0", bus.almost_full); end
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b want 0", bus.rd_valid); end
        n_checks++; if (bus.count !== 4'd0) begin n_errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_errors++; $display("FAIL reset_ovf got %b want 0", bus.overflow); end
    endtask

    task automatic test_order();
        res_st_cell_t c[3];
        for (int i = 0; i < 3; i++) c[i] = mk_cell(6'hA + 6'(i));
        for (int i = 0; i < 3; i++) begin
            drive(1, c[i], 0, 0);
            tick();
            n_checks++; if (bus.rd_valid !== 1'b1) begin n_errors++; $display("FAIL order_valid_%0d got %b want 1", i, bus.rd_valid); end
        end
        drive(0, '0, 0, 0);
        n_checks++; if (bus.count !== 4'd3) begin n_errors++; $display("FAIL order_count got %0d want 3", bus.count); end
        n_checks++; if (bus.rd_data !== c[0]) begin n_errors++; $display("FAIL order_head got %h want %h", bus.rd_data, c[0]); end
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, 1, 0);
            n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== c[i]) begin n_errors++; $display("FAIL order_pop_%0d got %b/%h want 1/%h", i, bus.rd_valid, bus.rd_data, c[i]); end
            tick();
        end
        drive(0, '0, 0, 0);
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_errors++; $display("FAIL order_empty got %b want 0", bus.rd_valid); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 7; i++) begin drive(1, mk_cell(6'(i)), 0, 0); tick(); end
        drive(0, '0, 0, 0);
        n_checks++; if (bus.almost_full !== 1'b1 || bus.full !== 1'b0) begin n_errors++; $display("FAIL full_af7 got af=%b full=%b want 1/0", bus.almost_full, bus.full); end
        drive(1, mk_cell(6'd7), 0, 0);
        tick();
        drive(0, '0, 0, 0);
        n_checks++; if (bus.full !== 1'b1) begin n_errors++; $display("FAIL full_8 got %b want 1", bus.full); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_errors++; $display("FAIL full_ovf_pre got %b want 0", bus.overflow); end
        drive(1, mk_cell(6'd8), 1, 0);
        n_checks++; if (bus.rd_data.tag !== 6'd0) begin n_errors++; $display("FAIL full_head got %0d want 0", bus.rd_data.tag); end
        tick();
        drive(0, '0, 0, 0);
        n_checks++; if (bus.overflow !== 1'b1) begin n_errors++; $display("FAIL full_ovf got %b want 1", bus.overflow); end
        n_checks++; if (bus.count !== 4'd7) begin n_errors++; $display("FAIL full_count got %0d want 7", bus.count); end
        n_checks++; if (bus.rd_data.tag !== 6'd1) begin n_errors++; $display("FAIL full_next got %0d want 1", bus.rd_data.tag); end
    endtask

    task automatic test_flush();
        while (m_q.size() > 5) begin drive(0, '0, 1, 0); tick(); end
        drive(0, '0, 0, 0);
        n_checks++; if (bus.count !== 4'd5) begin n_errors++; $display("FAIL flush_pre got %0d want 5", bus.count); end
        drive(1, mk_cell(6'h3f), 1, 1);
        tick();
        drive(0, '0, 0, 0);
        n_checks++; if (bus.count !== 4'd0) begin n_errors++; $display("FAIL flush_count got %0d want 0", bus.count); end
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_errors++; $display("FAIL flush_valid got %b want 0", bus.rd_valid); end
        n_checks++; if (bus.overflow !== 1'b1) begin n_errors++; $display("FAIL flush_ovf got %b want 1", bus.overflow); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin drive(1, mk_cell(6'(16 + i)), 0, 0); tick(); end
        for (int i = 0; i < 20; i++) begin
            drive(1, mk_cell(6'(20 + i)), 1, 0);
            n_checks++; if (bus.rd_data !== m_q[0]) begin n_errors++; $display("FAIL b2b_data_%0d got %h want %h", i, bus.rd_data, m_q[0]); end
            tick();
            n_checks++; if (bus.count !== 4'd4) begin n_errors++; $display("FAIL b2b_count_%0d got %0d want 4", i, bus.count); end
        end
    endtask

    task automatic test_rst_mid();
        while (m_q.size() < 6) begin drive(1, mk_cell(6'h2a), 0, 0); tick(); end
        drive(0, '0, 0, 0);
        n_checks++; if (bus.count !== 4'd6 || bus.overflow !== 1'b1) begin n_errors++; $display("FAIL rstmid_pre got %0d/%b want 6/1", bus.count, bus.overflow); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if ({bus.full, bus.almost_full, bus.rd_valid, bus.overflow} !== 4'b0) begin n_errors++; $display("FAIL rstmid_flags got %b want 0000", {bus.full, bus.almost_full, bus.rd_valid, bus.overflow}); end
        n_checks++; if (bus.count !== 4'd0) begin n_errors++; $display("FAIL rstmid_count got %0d want 0", bus.count); end
    endtask

    task automatic test_bypass();
        res_st_cell_t x;
        x = mk_cell(6'h15);
        drive(1, x, 1, 0);
`ifdef QU_ISSUE_QUEUE_BYPASS_EN
        n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== x) begin n_errors++; $display("FAIL byp_same got %b/%h want 1/%h", bus.rd_valid, bus.rd_data, x); end
        tick();
        drive(0, '0, 0, 0);
        n_checks++; if (bus.count !== 4'd0 || bus.rd_valid !== 1'b0) begin n_errors++; $display("FAIL byp_next got %0d/%b want 0/0", bus.count, bus.rd_valid); end
`else
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_errors++; $display("FAIL byp_same got %b want 0", bus.rd_valid); end
        tick();
        drive(0, '0, 0, 0);
        n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== x) begin n_errors++; $display("FAIL byp_next got %b/%h want 1/%h", bus.rd_valid, bus.rd_data, x); end
        drive(0, '0, 1, 0);
        tick();
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit ev;
            res_st_cell_t ed;
            drive($urandom_range(0, 99) < 60, mk_cell(6'($urandom)),
                  $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 3);
            ev = (m_q.size() != 0) || (BYP && bus.wr_en && !bus.flush);
            ed = (m_q.size() != 0) ? m_q[0] : bus.wr_data;
            n_checks++; if (bus.rd_valid !== ev) begin n_errors++; $display("FAIL rnd_valid_%0d got %b want %b", i, bus.rd_valid, ev); end
            if (ev) begin
                n_checks++; if (bus.rd_data !== ed) begin n_errors++; $display("FAIL rnd_data_%0d got %h want %h", i, bus.rd_data, ed); end
            end
            n_checks++; if (bus.count !== 4'(m_q.size())) begin n_errors++; $display("FAIL rnd_count_%0d got %0d want %0d", i, bus.count, m_q.size()); end
            n_checks++; if (bus.full !== (m_q.size() == DEPTH) || bus.almost_full !== (m_q.size() >= AF)) begin n_errors++; $display("FAIL rnd_flags_%0d got %b%b size %0d", i, bus.full, bus.almost_full, m_q.size()); end
            n_checks++; if (bus.overflow !== m_ovf) begin n_errors++; $display("FAIL rnd_ovf_%0d got %b want %b", i, bus.overflow, m_ovf); end
            tick();
        end
    endtask

    initial begin
        drive(0, '0, 0, 0);
        @(negedge clk);
        test_reset();
        test_order();
        test_full();
        test_flush();
        test_back_to_back();
        test_rst_mid();
        test_bypass();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
